// File: rtl/id_operand_stage_if.sv
// Handshake bundles around the operand-fetch / ID-EX stage.
//
//   id_dec_if : decoder -> stage. The decoder is the master; it presents a
//               decoded instruction with in_valid, and the stage answers
//               with in_ready.
//   id_ex_if  : stage -> EX. The stage is the master; it presents the
//               registered operation with out_valid, and EX answers with
//               out_ready.
interface id_dec_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int AOP_W  = 8,
  parameter int ASEL_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [AOP_W-1:0]  dec_aluop;
  logic [ASEL_W-1:0] dec_alusel;
  logic              dec_reg1_read;
  logic              dec_reg2_read;
  logic [ADDR_W-1:0] dec_reg1_addr;
  logic [ADDR_W-1:0] dec_reg2_addr;
  logic [DATA_W-1:0] dec_imm;
  logic [ADDR_W-1:0] dec_wd;
  logic              dec_wreg;
  logic [1:0]        dec_cond;

  modport master (
    output in_valid, dec_aluop, dec_alusel, dec_reg1_read, dec_reg2_read,
           dec_reg1_addr, dec_reg2_addr, dec_imm, dec_wd, dec_wreg, dec_cond,
    input  in_ready
  );
  modport slave (
    input  in_valid, dec_aluop, dec_alusel, dec_reg1_read, dec_reg2_read,
           dec_reg1_addr, dec_reg2_addr, dec_imm, dec_wd, dec_wreg, dec_cond,
    output in_ready
  );
endinterface

interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int AOP_W  = 8,
  parameter int ASEL_W = 3
);
  logic              out_valid;
  logic              out_ready;
  logic [AOP_W-1:0]  ex_aluop;
  logic [ASEL_W-1:0] ex_alusel;
  logic [DATA_W-1:0] ex_reg1;
  logic [DATA_W-1:0] ex_reg2;
  logic [ADDR_W-1:0] ex_wd;
  logic              ex_wreg;

  modport master (
    output out_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
    input  out_ready
  );
  modport slave (
    input  out_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
    output out_ready
  );
endinterface

// File: rtl/id_operand_stage.sv
// Operand fetch and ID/EX pipeline register for the MIPS pipeline.
//
// Selects each operand from the immediate, r0, the youngest matching
// forwarding source or the register file. Stalls the decoder while a
// selected operand is still waiting on a load. Resolves MOVN/MOVZ write
// enables from the selected operand 2. Holds the result in a valid/ready
// output register that absorbs EX back-pressure and pipeline flushes.
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   dec (id_dec_if.slave) decoded instruction + in_valid/in_ready
//   reg1_data_i/reg2_data_i  combinational register-file read data
//   fwd_wreg/fwd_wd/fwd_wdata/fwd_is_load  forwarding sources, index 0 youngest
//   flush                 synchronous flush of the ID/EX register
//   ex (id_ex_if.master)  registered operation + out_valid/out_ready
//   stall_cnt             saturating count of load-use stall cycles
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int AOP_W   = 8,
  parameter int ASEL_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  id_dec_if.slave                   dec,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic                      flush,
  id_ex_if.master                   ex,
  output logic [15:0]               stall_cnt
);

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_NZ     = 2'b01,  // MOVN
    COND_Z      = 2'b10,  // MOVZ
    COND_NEVER  = 2'b11
  } wcond_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              from_load;  // winning source is a pending load
  } opnd_t;

  // Operand priority: immediate, then r0, then youngest forwarding match,
  // then register file. The loop walks from the oldest source down to
  // index 0 so the last hit, the youngest, overwrites any older one; an
  // older source therefore never hides a younger pending load.
  function automatic opnd_t select_opnd(
    input logic                      rd,
    input logic [ADDR_W-1:0]         addr,
    input logic [DATA_W-1:0]         rf_data,
    input logic [DATA_W-1:0]         imm,
    input logic [NUM_FWD-1:0]        f_wreg,
    input logic [NUM_FWD*ADDR_W-1:0] f_wd,
    input logic [NUM_FWD*DATA_W-1:0] f_wdata,
    input logic [NUM_FWD-1:0]        f_load
  );
    opnd_t o;
    o.data      = rf_data;
    o.from_load = 1'b0;
    if (!rd) begin
      o.data = imm;
    end else if (addr == '0) begin
      o.data = '0;
    end else begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (f_wreg[i] && (f_wd[i*ADDR_W +: ADDR_W] == addr)) begin
          o.data      = f_wdata[i*DATA_W +: DATA_W];
          o.from_load = f_load[i];
        end
      end
    end
    return o;
  endfunction

  opnd_t op1;
  opnd_t op2;
  logic  hazard;
  logic  accept;
  logic  wreg_res;

  // NOTE: every signal written here gets a value before any branch so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    op1 = select_opnd(dec.dec_reg1_read, dec.dec_reg1_addr, reg1_data_i,
                      dec.dec_imm, fwd_wreg, fwd_wd, fwd_wdata, fwd_is_load);
    op2 = select_opnd(dec.dec_reg2_read, dec.dec_reg2_addr, reg2_data_i,
                      dec.dec_imm, fwd_wreg, fwd_wd, fwd_wdata, fwd_is_load);

    // from_load is only ever set for an enabled, nonzero operand, and it
    // never depends on register-file data.
    hazard = dec.in_valid && (op1.from_load || op2.from_load);

    wreg_res = 1'b0;
    case (wcond_e'(dec.dec_cond))
      COND_ALWAYS: wreg_res = dec.dec_wreg;
      COND_NZ:     wreg_res = dec.dec_wreg && (op2.data != '0);
      COND_Z:      wreg_res = dec.dec_wreg && (op2.data == '0);
      default:     wreg_res = 1'b0;
    endcase
  end

  assign dec.in_ready = !hazard && !flush && (!ex.out_valid || ex.out_ready);
  assign accept       = dec.in_valid && dec.in_ready;

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the payload is reset as well as out_valid so EX sees a clean
  // NOP after reset; it is a handful of flops, not a memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex.out_valid <= 1'b0;
      ex.ex_aluop  <= '0;
      ex.ex_alusel <= '0;
      ex.ex_reg1   <= '0;
      ex.ex_reg2   <= '0;
      ex.ex_wd     <= '0;
      ex.ex_wreg   <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      // Flush outranks everything, including a same-cycle EX handshake;
      // in_ready is already low during flush, so no accept can collide.
      if (flush) begin
        ex.out_valid <= 1'b0;
      end else if (accept) begin
        ex.out_valid <= 1'b1;
        ex.ex_aluop  <= dec.dec_aluop;
        ex.ex_alusel <= dec.dec_alusel;
        ex.ex_reg1   <= op1.data;
        ex.ex_reg2   <= op2.data;
        ex.ex_wd     <= dec.dec_wd;
        ex.ex_wreg   <= wreg_res;
      end else if (ex.out_valid && ex.out_ready) begin
        ex.out_valid <= 1'b0;
      end

      if (hazard && !flush && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
